// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// response error codes and the settle counter width.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_CLEAR = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_MOD   = 4'b1000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVF     = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for opcodes that are executed by the external ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 16-bit combinational ALU. Keeps an accumulator
// as operand A, holds the ALU inputs for a settle window, captures the
// result, writes it back and returns a response over valid/ready.
// Optional build macro ALU_SEQ_STICKY_ERROR_EN: ALU errors accumulate into a
// sticky register that blocks further ALU ops until CLEAR or reset.
//
//   state | meaning
//   IDLE  | ready for a command
//   EXEC  | ALU inputs held, settle counter running
//   RESP  | response presented until consumer takes it
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_operand,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [15:0] acc,
    output logic        busy,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [15:0]         acc_q, acc_d;
    logic [15:0]         alu_a_q, alu_a_d;
    logic [15:0]         alu_b_q, alu_b_d;
    logic [3:0]          alu_opcode_q, alu_opcode_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_result_q, rsp_result_d;
    logic [1:0]          rsp_error_q, rsp_error_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic [1:0]          sticky_q, sticky_d;
    logic                sticky_block;

`ifdef ALU_SEQ_STICKY_ERROR_EN
    assign sticky_block = (sticky_q != ERR_NONE);
`else
    assign sticky_block = 1'b0;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        sticky_d     = sticky_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (is_alu_op(cmd_opcode) && sticky_block) begin
                        // A latched error short-circuits the ALU entirely.
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = 32'd0;
                        rsp_error_d  = sticky_q;
                    end else if (is_alu_op(cmd_opcode)) begin
                        state_d      = EXEC;
                        cnt_d        = SETTLE_W'(1);
                        alu_a_d      = acc_q;
                        alu_b_d      = cmd_operand;
                        alu_opcode_d = cmd_opcode;
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = ERR_NONE;
                        rsp_result_d = {16'b0, acc_q};
                        case (cmd_opcode)
                            OP_NOP: ;
                            OP_LOAD: begin
                                acc_d        = cmd_operand;
                                rsp_result_d = {16'b0, cmd_operand};
                            end
                            OP_CLEAR: begin
                                acc_d        = 16'd0;
                                sticky_d     = ERR_NONE;
                                rsp_result_d = 32'd0;
                            end
                            default: begin
                                rsp_result_d = 32'd0;
                                rsp_error_d  = ERR_ILLEGAL;
                            end
                        endcase
                    end
                end
            end
            EXEC: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_error_d  = alu_error;
                    alu_opcode_d = OP_NOP;
                    if (alu_error == ERR_NONE) begin
                        acc_d = alu_result[15:0];
                    end
                    sticky_d = sticky_q | alu_error;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // FSM and all registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= 16'd0;
            alu_a_q      <= 16'd0;
            alu_b_q      <= 16'd0;
            alu_opcode_q <= OP_NOP;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_error_q  <= ERR_NONE;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            sticky_q     <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
`ifdef ALU_SEQ_STICKY_ERROR_EN
            sticky_q     <= sticky_d;
`else
            sticky_q     <= ERR_NONE;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign acc        = acc_q;
    assign busy       = busy_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural signed 16-bit ALU
// standing in for the breadboard. Latency is counted as rising edges after
// the accept edge until rsp_valid is seen (ALU op: SETTLE_CYCLES, local: 0).
module tb_alu_op_sequencer;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = 4'd0;
    logic [15:0] cmd_operand = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [15:0] acc;
    logic        busy;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .acc(acc), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_error(alu_error)
    );

    // Breadboard ALU: signed 16-bit operands, 32-bit sign-extended result.
    always_comb begin
        logic signed [31:0] sa, sb, r;
        sa = {{16{alu_a[15]}}, alu_a};
        sb = {{16{alu_b[15]}}, alu_b};
        r = 32'sd0;
        alu_error = 2'b00;
        case (alu_opcode)
            4'b0100: r = sa + sb;
            4'b0101: r = sa - sb;
            4'b0110: r = sa * sb;
            4'b0111: if (sb == 0) alu_error = 2'b10; else r = sa / sb;
            4'b1000: if (sb == 0) alu_error = 2'b10; else r = sa % sb;
            default: r = 32'sd0;
        endcase
        if ((alu_opcode == 4'b0100 || alu_opcode == 4'b0101) &&
            (r > 32'sd32767 || r < -32'sd32768)) alu_error = 2'b01;
        alu_result = r;
    end

    // Issue one command, wait for its response, then consume it.
    task automatic xact(input logic [3:0] op, input logic [15:0] opnd,
                        output int lat, output logic [31:0] res,
                        output logic [1:0] err, output logic [3:0] aop);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b1; cmd_opcode = op; cmd_operand = opnd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        aop = alu_opcode;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        res = rsp_result; err = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (acc !== 16'd0) begin bad++; $display("FAIL reset_acc got=%h exp=0", acc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({alu_a, alu_b, alu_opcode} !== 36'd0) begin bad++; $display("FAIL reset_alu_outs got=%h/%h/%h exp=0", alu_a, alu_b, alu_opcode); end
        total++; if ({rsp_result, rsp_error} !== 34'd0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0", rsp_result, rsp_error); end
    endtask

    task automatic test_add();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0001, 16'd100, lat, r, e, ao);
        total++; if (lat != 0) begin bad++; $display("FAIL load_latency got=%0d exp=0", lat); end
        total++; if (acc !== 16'd100) begin bad++; $display("FAIL load_acc got=%0d exp=100", acc); end
        xact(4'b0100, 16'd150, lat, r, e, ao);
        total++; if (ao !== 4'b0100) begin bad++; $display("FAIL add_alu_opcode got=%b exp=0100", ao); end
        total++; if (lat != SETTLE) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", lat, SETTLE); end
        total++; if (r !== 32'd250 || e !== 2'b00) begin bad++; $display("FAIL add_rsp got=%0d/%b exp=250/00", r, e); end
        total++; if (acc !== 16'd250) begin bad++; $display("FAIL add_acc got=%0d exp=250", acc); end
        total++; if (alu_opcode !== 4'b0000) begin bad++; $display("FAIL add_opcode_idle got=%b exp=0000", alu_opcode); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add_back_to_idle got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_sub_ovf();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0001, 16'hC000, lat, r, e, ao);
        xact(4'b0101, 16'h6000, lat, r, e, ao);
        total++; if (e !== 2'b01) begin bad++; $display("FAIL sub_ovf_err got=%b exp=01", e); end
        total++; if (r !== 32'hFFFF6000) begin bad++; $display("FAIL sub_ovf_result got=%h exp=ffff6000", r); end
        total++; if (acc !== 16'hC000) begin bad++; $display("FAIL sub_ovf_acc got=%h exp=c000", acc); end
    endtask

    task automatic test_mul_div_mod();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0001, 16'd477, lat, r, e, ao);
        xact(4'b0110, 16'd116, lat, r, e, ao);
        total++; if (r !== 32'h0000D824 || e !== 2'b00) begin bad++; $display("FAIL mul_rsp got=%h/%b exp=0000d824/00", r, e); end
        total++; if (acc !== 16'hD824) begin bad++; $display("FAIL mul_acc got=%h exp=d824", acc); end
        xact(4'b0001, 16'd100, lat, r, e, ao);
        xact(4'b0111, 16'd7, lat, r, e, ao);
        total++; if (r !== 32'd14 || acc !== 16'd14) begin bad++; $display("FAIL div_rsp got=%0d acc=%0d exp=14", r, acc); end
        xact(4'b1000, 16'd5, lat, r, e, ao);
        total++; if (r !== 32'd4 || acc !== 16'd4) begin bad++; $display("FAIL mod_rsp got=%0d acc=%0d exp=4", r, acc); end
    endtask

    task automatic test_div0();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0001, 16'd21, lat, r, e, ao);
        xact(4'b0111, 16'd0, lat, r, e, ao);
        total++; if (e !== 2'b10) begin bad++; $display("FAIL div0_err got=%b exp=10", e); end
        total++; if (acc !== 16'd21) begin bad++; $display("FAIL div0_acc got=%0d exp=21", acc); end
        xact(4'b0100, 16'd1, lat, r, e, ao);
`ifdef ALU_SEQ_STICKY_ERROR_EN
        total++; if (lat != 0 || e !== 2'b10 || r !== 32'd0) begin bad++; $display("FAIL sticky_block got lat=%0d err=%b res=%h exp=0/10/0", lat, e, r); end
        total++; if (ao !== 4'b0000 || acc !== 16'd21) begin bad++; $display("FAIL sticky_no_exec got op=%b acc=%0d exp=0000/21", ao, acc); end
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0100, 16'd1, lat, r, e, ao);
        total++; if (r !== 32'd1 || e !== 2'b00 || lat != SETTLE) begin bad++; $display("FAIL sticky_cleared got res=%0d err=%b lat=%0d exp=1/00/%0d", r, e, lat, SETTLE); end
`else
        total++; if (lat != SETTLE || e !== 2'b00 || r !== 32'd22) begin bad++; $display("FAIL after_div0 got lat=%0d err=%b res=%0d exp=%0d/00/22", lat, e, r, SETTLE); end
        total++; if (acc !== 16'd22) begin bad++; $display("FAIL after_div0_acc got=%0d exp=22", acc); end
`endif
    endtask

    task automatic test_backpressure_illegal();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        int n = 0;
        xact(4'b0010, 16'd0, lat, r, e, ao);
        xact(4'b0001, 16'd9, lat, r, e, ao);
        cmd_valid = 1'b1; cmd_opcode = 4'b0100; cmd_operand = 16'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd10 || rsp_error !== 2'b00 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got v=%b res=%0d err=%b rdy=%b exp=1/10/00/0", i, rsp_valid, rsp_result, rsp_error, cmd_ready);
            end
        end
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL hold_release got v=%b rdy=%b exp=0/1", rsp_valid, cmd_ready); end
        xact(4'b1111, 16'd3, lat, r, e, ao);
        total++; if (e !== 2'b11 || r !== 32'd0 || lat != 0) begin bad++; $display("FAIL illegal_rsp got err=%b res=%h lat=%0d exp=11/0/0", e, r, lat); end
        total++; if (acc !== 16'd10) begin bad++; $display("FAIL illegal_acc got=%0d exp=10", acc); end
        xact(4'b0000, 16'd77, lat, r, e, ao);
        total++; if (r !== 32'd10 || e !== 2'b00 || acc !== 16'd10) begin bad++; $display("FAIL nop_rsp got res=%0d err=%b acc=%0d exp=10/00/10", r, e, acc); end
    endtask

    task automatic test_rst_mid_exec();
        int lat; logic [31:0] r; logic [1:0] e; logic [3:0] ao;
        xact(4'b0001, 16'd5, lat, r, e, ao);
        cmd_valid = 1'b1; cmd_opcode = 4'b0100; cmd_operand = 16'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_exec_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (cmd_ready !== 1'b1 || acc !== 16'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_abort got rdy=%b acc=%0d v=%b exp=1/0/0", cmd_ready, acc, rsp_valid); end
        for (int i = 0; i < SETTLE + 2; i++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b0 || acc !== 16'd0) begin bad++; $display("FAIL rst_no_rsp%0d got v=%b acc=%0d exp=0/0", i, rsp_valid, acc); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_ovf();
        test_mul_div_mod();
        test_div0();
        test_backpressure_illegal();
        test_rst_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
